stage_ex_md: RTL and testbench



---
 rtl/stage_ex_md_if.sv | 45 ++++
 rtl/stage_ex_md.sv | 186 ++++++++++++++++++
 tb/tb_stage_ex_md.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_ex_md_if.sv
// Execute-stage bundle: ID/EX operands, forwarding sources and EX results.
// The master drives the instruction side; the slave is the execute stage.
interface stage_ex_md_if #(
    parameter int DATA_W  = 32,
    parameter int REGS_W  = 5,
    parameter int ALUOP_W = 4
);
    logic               in_valid;
    logic               md_en;
    logic [2:0]         md_op;
    logic [ALUOP_W-1:0] ALU_op;
    logic               ALU_src;
    logic [DATA_W-1:0]  reg_data1;
    logic [DATA_W-1:0]  reg_data2;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  EX_MEM_data;
    logic [DATA_W-1:0]  MEM_WB_data;
    logic [REGS_W-1:0]  ID_EX_rs1;
    logic [REGS_W-1:0]  ID_EX_rs2;
    logic [REGS_W-1:0]  EX_MEM_rd;
    logic [REGS_W-1:0]  MEM_WB_rd;
    logic               EX_MEM_RegWrite;
    logic               MEM_WB_RegWrite;
    logic               flush;
    logic               stall_req;
    logic               out_valid;
    logic [DATA_W-1:0]  result;
    logic [DATA_W-1:0]  data_out;

    modport master (
        output in_valid, md_en, md_op, ALU_op, ALU_src,
        output reg_data1, reg_data2, imm, EX_MEM_data, MEM_WB_data,
        output ID_EX_rs1, ID_EX_rs2, EX_MEM_rd, MEM_WB_rd,
        output EX_MEM_RegWrite, MEM_WB_RegWrite, flush,
        input  stall_req, out_valid, result, data_out
    );

    modport slave (
        input  in_valid, md_en, md_op, ALU_op, ALU_src,
        input  reg_data1, reg_data2, imm, EX_MEM_data, MEM_WB_data,
        input  ID_EX_rs1, ID_EX_rs2, EX_MEM_rd, MEM_WB_rd,
        input  EX_MEM_RegWrite, MEM_WB_RegWrite, flush,
        output stall_req, out_valid, result, data_out
    );
endinterface

// File: rtl/stage_ex_md.sv
// Execute stage: two-level operand forwarding, single-cycle ALU and a multi-cycle
// RV32M unit. ALU_op: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND, else src2.
module stage_ex_md #(
    parameter int DATA_W  = 32,
    parameter int REGS_W  = 5,
    parameter int ALUOP_W = 4,
    parameter int MUL_LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    stage_ex_md_if.slave  ex
);
    localparam int CNT_W = $clog2(DATA_W + MUL_LAT + 1);
    localparam int SH_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q, b_q, res_q, quo_q, dvs_q, rem_q;
    logic [2:0]        op_q;
    logic              q_neg_q, r_neg_q;

    // Forwarding: EX/MEM beats MEM/WB, x0 is never forwarded.
    logic [REGS_W-1:0] rs_idx   [2];
    logic [DATA_W-1:0] rf_data  [2];
    logic [DATA_W-1:0] fwd_data [2];
    assign rs_idx[0]  = ex.ID_EX_rs1;
    assign rs_idx[1]  = ex.ID_EX_rs2;
    assign rf_data[0] = ex.reg_data1;
    assign rf_data[1] = ex.reg_data2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic ex_hit, wb_hit;
            assign ex_hit = ex.EX_MEM_RegWrite && (ex.EX_MEM_rd != '0) && (ex.EX_MEM_rd == rs_idx[gi]);
            assign wb_hit = ex.MEM_WB_RegWrite && (ex.MEM_WB_rd != '0) && (ex.MEM_WB_rd == rs_idx[gi]);
            assign fwd_data[gi] = ex_hit ? ex.EX_MEM_data : (wb_hit ? ex.MEM_WB_data : rf_data[gi]);
        end
    endgenerate

    logic [DATA_W-1:0] src1, src2;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] alu_res;
    assign src1  = fwd_data[0];
    assign src2  = ex.ALU_src ? ex.imm : fwd_data[1];
    assign shamt = src2[SH_W-1:0];

    always_comb begin
        alu_res = src2;
        case (ex.ALU_op)
            ALUOP_W'(0): alu_res = src1 + src2;
            ALUOP_W'(1): alu_res = src1 - src2;
            ALUOP_W'(2): alu_res = src1 << shamt;
            ALUOP_W'(3): alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1) < $signed(src2))};
            ALUOP_W'(4): alu_res = {{(DATA_W-1){1'b0}}, (src1 < src2)};
            ALUOP_W'(5): alu_res = src1 ^ src2;
            ALUOP_W'(6): alu_res = src1 >> shamt;
            ALUOP_W'(7): alu_res = $signed(src1) >>> shamt;
            ALUOP_W'(8): alu_res = src1 | src2;
            ALUOP_W'(9): alu_res = src1 & src2;
            default:     alu_res = src2;
        endcase
    end

    // Multiplier reads live operands only when MUL_LAT==1 finishes straight from IDLE.
    logic [DATA_W-1:0]   mul_a, mul_b, mul_res;
    logic [2:0]          mul_op;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;
    assign mul_a  = (state_q == IDLE) ? src1 : a_q;
    assign mul_b  = (state_q == IDLE) ? src2 : b_q;
    assign mul_op = (state_q == IDLE) ? ex.md_op : op_q;
    assign ext_a  = (mul_op == 3'd1 || mul_op == 3'd2) ? {{DATA_W{mul_a[DATA_W-1]}}, mul_a}
                                                       : {{DATA_W{1'b0}}, mul_a};
    assign ext_b  = (mul_op == 3'd1) ? {{DATA_W{mul_b[DATA_W-1]}}, mul_b}
                                     : {{DATA_W{1'b0}}, mul_b};
    assign prod    = ext_a * ext_b;
    assign mul_res = (mul_op == 3'd0) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];

    logic              div_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [DATA_W-1:0] mag_a, mag_b, special_res;
    assign div_signed  = ~ex.md_op[0];
    assign a_neg       = div_signed & src1[DATA_W-1];
    assign b_neg       = div_signed & src2[DATA_W-1];
    assign mag_a       = a_neg ? -src1 : src1;
    assign mag_b       = b_neg ? -src2 : src2;
    assign div_zero    = (src2 == '0);
    assign div_ovf     = div_signed && (src1 == {1'b1, {(DATA_W-1){1'b0}}}) && (src2 == '1);
    assign special_res = div_zero ? (ex.md_op[1] ? src1 : '1) : (ex.md_op[1] ? '0 : src1);

    // One restoring step: shift the next dividend bit in, keep the difference if non-negative.
    logic [DATA_W:0]   rem_shift, trial;
    logic [DATA_W-1:0] rem_nx, quo_nx, q_fix, r_fix;
    assign rem_shift = {rem_q, quo_q[DATA_W-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};
    assign rem_nx    = trial[DATA_W] ? rem_shift[DATA_W-1:0] : trial[DATA_W-1:0];
    assign quo_nx    = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
    assign q_fix     = q_neg_q ? -quo_nx : quo_nx;
    assign r_fix     = r_neg_q ? -rem_nx : rem_nx;

    logic accept;
    assign accept = (state_q == IDLE) && ex.in_valid && ex.md_en && !ex.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (ex.flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    a_q     <= src1;
                    b_q     <= src2;
                    op_q    <= ex.md_op;
                    cnt_q   <= '0;
                    quo_q   <= mag_a;
                    dvs_q   <= mag_b;
                    rem_q   <= '0;
                    q_neg_q <= a_neg ^ b_neg;
                    r_neg_q <= a_neg;
                    if (!ex.md_op[2]) begin
                        if (MUL_LAT == 1) begin
                            res_q   <= mul_res;
                            state_q <= DONE;
                        end else begin
                            state_q <= MUL;
                        end
                    end else if (div_zero || div_ovf) begin
                        res_q   <= special_res;
                        state_q <= DONE;
                    end else begin
                        state_q <= DIV;
                    end
                end
                MUL: begin
                    if (cnt_q == CNT_W'(MUL_LAT - 2)) begin
                        res_q   <= mul_res;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        res_q   <= op_q[1] ? r_fix : q_fix;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ex.stall_req = 1'b0;
        ex.out_valid = 1'b0;
        if (rst_n && !ex.flush) begin
            case (state_q)
                IDLE: begin
                    ex.stall_req = ex.in_valid & ex.md_en;
                    ex.out_valid = ex.in_valid & ~ex.md_en;
                end
                MUL, DIV: ex.stall_req = 1'b1;
                default:  ex.out_valid = 1'b1;
            endcase
        end
    end

    assign ex.result   = (state_q == IDLE) ? alu_res : res_q;
    assign ex.data_out = fwd_data[1];
endmodule

// File: tb/tb_stage_ex_md.sv
// Directed and randomized checks of stage_ex_md against an arithmetic reference model.
module tb_stage_ex_md;
    localparam int DATA_W  = 32;
    localparam int REGS_W  = 5;
    localparam int ALUOP_W = 4;
    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    always #5 clk = ~clk;

    stage_ex_md_if #(.DATA_W(DATA_W), .REGS_W(REGS_W), .ALUOP_W(ALUOP_W)) bus ();

    stage_ex_md #(.DATA_W(DATA_W), .REGS_W(REGS_W), .ALUOP_W(ALUOP_W), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_m(input logic [4:0] rs, input logic [31:0] rf);
        if (bus.EX_MEM_RegWrite && bus.EX_MEM_rd != 0 && bus.EX_MEM_rd == rs) return bus.EX_MEM_data;
        if (bus.MEM_WB_RegWrite && bus.MEM_WB_rd != 0 && bus.MEM_WB_rd == rs) return bus.MEM_WB_data;
        return rf;
    endfunction

    function automatic logic [31:0] alu_m(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh = int'(b[4:0]);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> sh;
            4'd7: return $signed(a) >>> sh;
            4'd8: return a | b;
            4'd9: return a & b;
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] md_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int ia = $signed(a);
        int ib = $signed(b);
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = longint'(ia) * longint'(ib); return p[31:0]; end
            3'd1: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
            3'd2: begin p = longint'(ia) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int md_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DATA_W + 1;
    endfunction

    task automatic set_idle();
        bus.in_valid = 0; bus.md_en = 0; bus.md_op = 0; bus.ALU_op = 0; bus.ALU_src = 0;
        bus.reg_data1 = 0; bus.reg_data2 = 0; bus.imm = 0;
        bus.EX_MEM_data = 0; bus.MEM_WB_data = 0;
        bus.ID_EX_rs1 = 0; bus.ID_EX_rs2 = 0; bus.EX_MEM_rd = 0; bus.MEM_WB_rd = 0;
        bus.EX_MEM_RegWrite = 0; bus.MEM_WB_RegWrite = 0; bus.flush = 0;
    endtask

    task automatic set_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        set_idle();
        bus.in_valid = 1; bus.md_en = 1; bus.md_op = op;
        bus.ID_EX_rs1 = 5'd1; bus.ID_EX_rs2 = 5'd2; bus.reg_data1 = a; bus.reg_data2 = b;
    endtask

    // Called just after inputs were driven at a negedge; ends in the DONE cycle.
    task automatic md_cycle(input string tag, input bit use_want, input logic [31:0] want);
        logic [31:0] a, b, exp;
        int lat;
        #1;
        a   = fwd_m(bus.ID_EX_rs1, bus.reg_data1);
        b   = bus.ALU_src ? bus.imm : fwd_m(bus.ID_EX_rs2, bus.reg_data2);
        exp = use_want ? want : md_m(bus.md_op, a, b);
        lat = md_lat(bus.md_op, a, b);
        chk({tag, "_accept_stall"}, 32'(bus.stall_req), 32'd1);
        chk({tag, "_accept_valid"}, 32'(bus.out_valid), 32'd0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            bus.EX_MEM_data = $urandom; bus.MEM_WB_data = $urandom;
            #1;
            chk({tag, "_busy_stall"}, 32'(bus.stall_req), 32'd1);
            chk({tag, "_busy_valid"}, 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        bus.EX_MEM_data = $urandom;
        #1;
        chk({tag, "_done_stall"}, 32'(bus.stall_req), 32'd0);
        chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_result"}, bus.result, exp);
        n_txn++;
        $display("txn %0d %s md_op=%0d a=%h b=%h lat=%0d result=%h expected=%h",
                 n_txn, tag, bus.md_op, a, b, lat, bus.result, exp);
    endtask

    task automatic alu_cycle(input string tag);
        logic [31:0] a, b, exp, st;
        logic        ov;
        #1;
        a   = fwd_m(bus.ID_EX_rs1, bus.reg_data1);
        st  = fwd_m(bus.ID_EX_rs2, bus.reg_data2);
        b   = bus.ALU_src ? bus.imm : st;
        exp = alu_m(bus.ALU_op, a, b);
        ov  = bus.in_valid & ~bus.flush;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, "_stall"}, 32'(bus.stall_req), 32'd0);
        chk({tag, "_data_out"}, bus.data_out, st);
        if (ov) chk({tag, "_result"}, bus.result, exp);
        n_txn++;
        $display("txn %0d %s alu_op=%0d a=%h b=%h valid=%0d result=%h expected=%h",
                 n_txn, tag, bus.ALU_op, a, b, bus.out_valid, bus.result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        bus.in_valid = 1;
        #2;
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; bus.in_valid = 0;
        #1;
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_stall", 32'(bus.stall_req), 32'd0);

        // ALU with both forwarding levels matching: EX/MEM must win.
        @(negedge clk);
        set_idle();
        bus.in_valid = 1; bus.ALU_op = 4'd0;
        bus.ID_EX_rs1 = 5'd5; bus.ID_EX_rs2 = 5'd6; bus.reg_data1 = 32'd4; bus.reg_data2 = 32'd3;
        bus.EX_MEM_rd = 5'd5; bus.EX_MEM_RegWrite = 1; bus.EX_MEM_data = 32'd7;
        bus.MEM_WB_rd = 5'd5; bus.MEM_WB_RegWrite = 1; bus.MEM_WB_data = 32'd9;
        alu_cycle("alu_fwd");
        chk("alu_fwd_value", bus.result, 32'd10);
        @(negedge clk);
        bus.ID_EX_rs1 = 5'd0; bus.EX_MEM_rd = 5'd0; bus.MEM_WB_rd = 5'd0;
        alu_cycle("alu_x0");
        chk("alu_x0_value", bus.result, 32'd7);

        @(negedge clk); set_md(3'd0, 32'hFFFF_FFFF, 32'd2); md_cycle("mul",    1, 32'hFFFF_FFFE);
        @(negedge clk); set_md(3'd3, 32'hFFFF_FFFF, 32'd2); md_cycle("mulhu",  1, 32'h0000_0001);
        @(negedge clk); set_md(3'd1, 32'hFFFF_FFFF, 32'd2); md_cycle("mulh",   1, 32'hFFFF_FFFF);
        @(negedge clk); set_md(3'd2, 32'hFFFF_FFFF, 32'd2); md_cycle("mulhsu", 1, 32'hFFFF_FFFF);
        @(negedge clk); set_md(3'd4, 32'hFFFF_FFF9, 32'd2); md_cycle("div",    1, 32'hFFFF_FFFD);
        @(negedge clk); set_md(3'd6, 32'hFFFF_FFF9, 32'd2); md_cycle("rem",    1, 32'hFFFF_FFFF);
        @(negedge clk); set_md(3'd5, 32'd100, 32'd7);       md_cycle("divu",   1, 32'd14);
        @(negedge clk); set_md(3'd4, 32'd5, 32'd0);         md_cycle("div0",   1, 32'hFFFF_FFFF);
        @(negedge clk); set_md(3'd6, 32'd5, 32'd0);         md_cycle("rem0",   1, 32'd5);
        @(negedge clk); set_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF); md_cycle("divovf", 1, 32'h8000_0000);
        @(negedge clk); set_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF); md_cycle("removf", 1, 32'd0);

        // rs1 forwarded from EX/MEM; md_cycle scrambles EX_MEM_data after accept.
        @(negedge clk);
        set_md(3'd0, 32'd1, 32'd7);
        bus.ID_EX_rs1 = 5'd3; bus.EX_MEM_rd = 5'd3; bus.EX_MEM_RegWrite = 1; bus.EX_MEM_data = 32'd6;
        md_cycle("mul_fwd", 1, 32'd42);

        // Flush in the accept cycle must not start the operation.
        @(negedge clk); set_md(3'd0, 32'd3, 32'd3); bus.flush = 1; #1;
        chk("flush_accept_stall", 32'(bus.stall_req), 32'd0);
        chk("flush_accept_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk); set_idle(); #1;
        chk("flush_accept_idle_stall", 32'(bus.stall_req), 32'd0);

        // Flush during the 10th divide cycle.
        @(negedge clk); set_md(3'd5, 32'd1000, 32'd3);
        for (int k = 1; k < 10; k++) @(negedge clk);
        #1 chk("div_busy_stall", 32'(bus.stall_req), 32'd1);
        @(negedge clk); bus.flush = 1; #1;
        chk("div_flush_stall", 32'(bus.stall_req), 32'd0);
        chk("div_flush_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk); set_idle(); #1;
        chk("after_flush_stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk); set_md(3'd0, 32'd6, 32'd7); md_cycle("mul_after_flush", 1, 32'd42);

        // Reset while multiplying.
        @(negedge clk); set_md(3'd0, 32'd5, 32'd5);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rst_mul_stall", 32'(bus.stall_req), 32'd0);
        chk("rst_mul_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1; set_idle(); #1;
        chk("rst_idle_stall", 32'(bus.stall_req), 32'd0);
        chk("rst_idle_valid", 32'(bus.out_valid), 32'd0);

        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            set_idle();
            bus.ID_EX_rs1 = 5'($urandom_range(0, 3));  bus.ID_EX_rs2 = 5'($urandom_range(0, 3));
            bus.EX_MEM_rd = 5'($urandom_range(0, 3));  bus.MEM_WB_rd = 5'($urandom_range(0, 3));
            bus.EX_MEM_RegWrite = 1'($urandom);        bus.MEM_WB_RegWrite = 1'($urandom);
            bus.reg_data1 = $urandom; bus.reg_data2 = $urandom; bus.imm = $urandom;
            bus.EX_MEM_data = $urandom; bus.MEM_WB_data = $urandom;
            bus.ALU_src = 1'($urandom); bus.ALU_op = 4'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                bus.in_valid = 1; bus.md_en = 1; bus.md_op = 3'($urandom);
                if ($urandom_range(0, 5) == 0) begin
                    bus.ALU_src = 1; bus.imm = 32'd0;
                end
                md_cycle("rand_md", 0, 32'd0);
            end else begin
                bus.in_valid = ($urandom_range(0, 7) != 0);
                bus.flush    = ($urandom_range(0, 7) == 0);
                alu_cycle("rand_alu");
            end
        end

        @(negedge clk);
        set_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
